// File: rtl/osiris_loader_pkg.sv
// Shared constants and types for the framed UART-to-Wishbone loader.
package osiris_loader_pkg;

    // Frame start marker; every other byte is dropped while idle.
    localparam logic [7:0] SYNC_BYTE    = 8'hA5;

    // Response status codes returned after each frame.
    localparam logic [7:0] RESP_ACK     = 8'h06;
    localparam logic [7:0] RESP_BAD_CHK = 8'h15;
    localparam logic [7:0] RESP_BAD_TGT = 8'h16;
    localparam logic [7:0] RESP_BUS_ERR = 8'h17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_WB_WRITE,
        ST_CHK,
        ST_RESP
    } loader_state_t;

    // States in which the loader takes bytes from the receiver.
    function automatic logic takes_rx(input loader_state_t s);
        return !(s == ST_WB_WRITE || s == ST_RESP);
    endfunction

endpackage

// File: rtl/loader_wb_master.sv
// Single Wishbone classic write handshake with timeout and one-hot target select.
module loader_wb_master #(
    parameter int N_TARGETS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [6:0]           tgt_idx,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    output logic                 cyc,
    output logic [N_TARGETS-1:0] tgt,
    output logic                 done,
    output logic                 error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            cyc_reg;
    logic [TO_W-1:0] cnt_reg;
    logic            timeout;

    // The last allowed edge is the one where the count has reached TIMEOUT_CYCLES-1.
    assign timeout = (cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign done    = cyc_reg && (wb_ack || wb_err || timeout);
    // A simultaneous ack wins over a timeout, but not over an explicit error.
    assign error   = cyc_reg && (wb_err || (timeout && !wb_ack));
    assign cyc     = cyc_reg;

    // Cycle flag and per-write edge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (start) begin
            cyc_reg <= 1'b1;
            cnt_reg <= '0;
        end else if (done) begin
            cyc_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (cyc_reg) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // One-hot target decode, only meaningful while a cycle is open.
    generate
        for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_tgt
            assign tgt[gi] = cyc_reg && (tgt_idx == 7'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_wb_loader.sv
// Framed UART byte-stream loader driving a multi-target Wishbone write master.
module uart_wb_loader
    import osiris_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int N_TARGETS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_rx_ready,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [ADDR_WIDTH-1:0]   o_wb_adr,
    output logic [DATA_WIDTH-1:0]   o_wb_dat,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    output logic [N_TARGETS-1:0]    o_wb_tgt,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_err,
    output logic                    o_core_hold,
    output logic                    o_busy
);

    localparam int ABYTES = ADDR_WIDTH / 8;
    localparam int DBYTES = DATA_WIDTH / 8;
    localparam int CNT_W  = 16;

    loader_state_t state_reg, state_next;

    logic [CNT_W-1:0]      byte_cnt_reg;
    logic [ADDR_WIDTH-1:0] adr_reg;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [7:0]            len_reg;
    logic [7:0]            chk_reg;
    logic [6:0]            tgt_reg;
    logic                  bad_tgt_reg;
    logic                  wb_fail_reg;
    logic [7:0]            tx_data_reg;

    logic rx_ready_reg, rx_ready_next;
    logic tx_valid_reg, tx_valid_next;
    logic hold_reg, hold_next;

    logic                  accept;
    logic                  addr_last;
    logic                  word_last;
    logic                  skip_word;
    logic                  wb_start;
    logic                  wb_cyc;
    logic                  wb_done;
    logic                  wb_error;
    logic [N_TARGETS-1:0]  wb_tgt;
    logic [7:0]            status;
    logic [ADDR_WIDTH+7:0] adr_shift;
    logic [DATA_WIDTH+7:0] word_shift;

    assign accept    = i_rx_valid && rx_ready_reg;
    assign addr_last = (byte_cnt_reg == CNT_W'(ABYTES - 1));
    assign word_last = (byte_cnt_reg == CNT_W'(DBYTES - 1));
    // After a bad target or a failed write, words are drained without touching the bus.
    assign skip_word = bad_tgt_reg || wb_fail_reg;
    assign wb_start  = (state_reg == ST_DATA) && accept && word_last && !skip_word;

    // Little-endian assembly: each new byte enters at the top and shifts down.
    assign adr_shift  = {i_rx_data, adr_reg};
    assign word_shift = {i_rx_data, word_reg};

    // Final status, evaluated while the CHK byte is on the receiver port.
    assign status = bad_tgt_reg                   ? RESP_BAD_TGT :
                    wb_fail_reg                   ? RESP_BUS_ERR :
                    ((chk_reg ^ i_rx_data) != 8'h00) ? RESP_BAD_CHK : RESP_ACK;

    loader_wb_master #(
        .N_TARGETS      (N_TARGETS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wb_master (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (wb_start),
        .tgt_idx (tgt_reg),
        .wb_ack  (i_wb_ack),
        .wb_err  (i_wb_err),
        .cyc     (wb_cyc),
        .tgt     (wb_tgt),
        .done    (wb_done),
        .error   (wb_error)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame sequencing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (accept && i_rx_data == SYNC_BYTE) state_next = ST_CMD;
            ST_CMD:      if (accept) state_next = ST_ADDR;
            ST_ADDR:     if (accept && addr_last) state_next = ST_LEN;
            ST_LEN:      if (accept) state_next = ST_DATA;
            ST_DATA: begin
                if (accept && word_last) begin
                    if (!skip_word)          state_next = ST_WB_WRITE;
                    else if (len_reg == 8'd0) state_next = ST_CHK;
                end
            end
            ST_WB_WRITE: if (wb_done) state_next = (len_reg == 8'd0) ? ST_CHK : ST_DATA;
            ST_CHK:      if (accept) state_next = ST_RESP;
            ST_RESP:     if (tx_valid_reg && i_tx_ready) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Registered handshake outputs follow the state being entered.
    always_comb begin
        rx_ready_next = takes_rx(state_next);
        tx_valid_next = (state_next == ST_RESP);
        hold_next     = (state_next != ST_IDLE);
    end

    // Output registers; core hold has no combinational path from inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_reg <= 1'b0;
            tx_valid_reg <= 1'b0;
            hold_reg     <= 1'b0;
        end else begin
            rx_ready_reg <= rx_ready_next;
            tx_valid_reg <= tx_valid_next;
            hold_reg     <= hold_next;
        end
    end

    // Frame datapath: target, address counter, word assembler, length, checksum, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg <= '0;
            adr_reg      <= '0;
            word_reg     <= '0;
            len_reg      <= '0;
            chk_reg      <= '0;
            tgt_reg      <= '0;
            bad_tgt_reg  <= 1'b0;
            wb_fail_reg  <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept && i_rx_data == SYNC_BYTE) begin
                        chk_reg      <= '0;
                        bad_tgt_reg  <= 1'b0;
                        wb_fail_reg  <= 1'b0;
                        byte_cnt_reg <= '0;
                    end
                end
                ST_CMD: begin
                    if (accept) begin
                        tgt_reg      <= i_rx_data[6:0];
                        bad_tgt_reg  <= ({1'b0, i_rx_data[6:0]} >= 8'(N_TARGETS));
                        chk_reg      <= chk_reg ^ i_rx_data;
                        byte_cnt_reg <= '0;
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        adr_reg      <= adr_shift[ADDR_WIDTH+7:8];
                        chk_reg      <= chk_reg ^ i_rx_data;
                        byte_cnt_reg <= addr_last ? '0 : byte_cnt_reg + 1'b1;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        len_reg      <= i_rx_data;
                        chk_reg      <= chk_reg ^ i_rx_data;
                        byte_cnt_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        word_reg     <= word_shift[DATA_WIDTH+7:8];
                        chk_reg      <= chk_reg ^ i_rx_data;
                        byte_cnt_reg <= word_last ? '0 : byte_cnt_reg + 1'b1;
                        if (word_last && skip_word) begin
                            adr_reg <= adr_reg + ADDR_WIDTH'(DBYTES);
                            len_reg <= len_reg - 1'b1;
                        end
                    end
                end
                ST_WB_WRITE: begin
                    if (wb_done) begin
                        adr_reg <= adr_reg + ADDR_WIDTH'(DBYTES);
                        len_reg <= len_reg - 1'b1;
                        if (wb_error) wb_fail_reg <= 1'b1;
                    end
                end
                ST_CHK: begin
                    if (accept) tx_data_reg <= status;
                end
                ST_RESP: begin
                    if (tx_valid_reg && i_tx_ready) tx_data_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_rx_ready  = rx_ready_reg;
    assign o_tx_valid  = tx_valid_reg;
    assign o_tx_data   = tx_data_reg;
    assign o_core_hold = hold_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_wb_cyc    = wb_cyc;
    assign o_wb_stb    = wb_cyc;
    assign o_wb_we     = wb_cyc;
    assign o_wb_sel    = {DBYTES{wb_cyc}};
    assign o_wb_adr    = wb_cyc ? adr_reg  : '0;
    assign o_wb_dat    = wb_cyc ? word_reg : '0;
    assign o_wb_tgt    = wb_tgt;

endmodule

// File: tb/tb_uart_wb_loader.sv
// Directed frame-table bench for uart_wb_loader with a registered-ack Wishbone slave.
module tb_uart_wb_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic [1:0]  wb_tgt;
    logic        wb_ack;
    logic        wb_err;
    logic        core_hold;
    logic        busy;
    logic        slave_en;

    uart_wb_loader #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .N_TARGETS      (2),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .o_wb_tgt    (wb_tgt),
        .i_wb_ack    (wb_ack),
        .i_wb_err    (wb_err),
        .o_core_hold (core_hold),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // Slave acknowledges one cycle after it sees a strobe, unless stalled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_ack <= 1'b0;
        else        wb_ack <= wb_cyc && wb_stb && !wb_ack && slave_en;
    end

    // Bus monitor: counts cycles with cyc high and logs each acknowledged write.
    int          cyc_total = 0;
    int          wr_total  = 0;
    logic [31:0] wr_adr [0:31];
    logic [31:0] wr_dat [0:31];
    logic [1:0]  wr_tgt [0:31];
    logic [3:0]  wr_sel [0:31];
    logic        wr_we  [0:31];
    always @(negedge clk) begin
        if (wb_cyc) cyc_total <= cyc_total + 1;
        if (wb_cyc && wb_stb && wb_ack && wr_total < 32) begin
            wr_adr[wr_total] <= wb_adr;
            wr_dat[wr_total] <= wb_dat;
            wr_tgt[wr_total] <= wb_tgt;
            wr_sel[wr_total] <= wb_sel;
            wr_we[wr_total]  <= wb_we;
            wr_total         <= wr_total + 1;
        end
    end

    typedef struct {
        logic [159:0] bytes;
        int           n;
        bit           slave_en;
        logic [7:0]   status;
        int           nwr;
        int           ncyc;
        logic [31:0]  adr0, dat0, adr1, dat1;
        logic [1:0]   tgt0, tgt1;
    } vec_t;

    vec_t vecs [0:5];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [159:0] align(input logic [159:0] raw, input int n);
        return raw << (8 * (20 - n));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int budget = 600;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_accept_timeout: byte %02h not accepted", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input int i);
        vec_t        v;
        int          wr0, cy0;
        bit          seen;
        logic [7:0]  b;
        v    = vecs[i];
        wr0  = wr_total;
        cy0  = cyc_total;
        seen = 1'b0;
        slave_en = v.slave_en;
        for (int k = 0; k < v.n; k++) begin
            b = v.bytes[159 - 8*k -: 8];
            send_byte(b);
            if (b == 8'hA5) seen = 1'b1;
            check($sformatf("f%0d hold_byte%0d", i, k), 32'(core_hold), 32'(seen));
        end
        check($sformatf("f%0d tx_valid_rise", i), 32'(tx_valid), 32'd1);
        check($sformatf("f%0d status", i), 32'(tx_data), 32'(v.status));
        check($sformatf("f%0d hold_resp", i), 32'(core_hold), 32'd1);
        check($sformatf("f%0d rx_ready_resp", i), 32'(rx_ready), 32'd0);
        @(negedge clk);
        check($sformatf("f%0d tx_stable", i), {23'd0, tx_valid, tx_data},
              {23'd0, 1'b1, v.status});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check($sformatf("f%0d hold_clear", i), 32'(core_hold), 32'd0);
        check($sformatf("f%0d tx_valid_drop", i), 32'(tx_valid), 32'd0);
        check($sformatf("f%0d busy_clear", i), 32'(busy), 32'd0);
        check($sformatf("f%0d nwrites", i), 32'(wr_total - wr0), 32'(v.nwr));
        check($sformatf("f%0d cyc_cycles", i), 32'(cyc_total - cy0), 32'(v.ncyc));
        for (int w = 0; w < v.nwr && w < 2; w++) begin
            check($sformatf("f%0d w%0d adr", i, w), wr_adr[wr0 + w], (w == 0) ? v.adr0 : v.adr1);
            check($sformatf("f%0d w%0d dat", i, w), wr_dat[wr0 + w], (w == 0) ? v.dat0 : v.dat1);
            check($sformatf("f%0d w%0d tgt", i, w), 32'(wr_tgt[wr0 + w]),
                  32'((w == 0) ? v.tgt0 : v.tgt1));
            check($sformatf("f%0d w%0d sel_we", i, w), {27'd0, wr_we[wr0 + w], wr_sel[wr0 + w]},
                  32'h1F);
        end
        $display("[TB] frame %0d: status %02h, %0d writes, %0d cyc cycles",
                 i, tx_data_seen(v.status), wr_total - wr0, cyc_total - cy0);
    endtask

    function automatic logic [7:0] tx_data_seen(input logic [7:0] s);
        return s;
    endfunction

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{bytes: align(160'hA5_00_10_00_00_00_00_EF_BE_AD_DE_32, 12), n: 12,
                    slave_en: 1'b1, status: 8'h06, nwr: 1, ncyc: 2,
                    adr0: 32'h10, dat0: 32'hDEADBEEF, adr1: 32'h0, dat1: 32'h0,
                    tgt0: 2'b01, tgt1: 2'b00};
        vecs[1] = '{bytes: align(160'hA5_00_10_00_00_00_00_EF_BE_AD_DE_33, 12), n: 12,
                    slave_en: 1'b1, status: 8'h15, nwr: 1, ncyc: 2,
                    adr0: 32'h10, dat0: 32'hDEADBEEF, adr1: 32'h0, dat1: 32'h0,
                    tgt0: 2'b01, tgt1: 2'b00};
        vecs[2] = '{bytes: align(160'hA5_05_10_00_00_00_00_EF_BE_AD_DE_37, 12), n: 12,
                    slave_en: 1'b1, status: 8'h16, nwr: 0, ncyc: 0,
                    adr0: 32'h0, dat0: 32'h0, adr1: 32'h0, dat1: 32'h0,
                    tgt0: 2'b00, tgt1: 2'b00};
        vecs[3] = '{bytes: align(160'hA5_01_20_00_00_00_01_44_33_22_11_88_77_66_55_A8, 16), n: 16,
                    slave_en: 1'b0, status: 8'h17, nwr: 0, ncyc: 255,
                    adr0: 32'h0, dat0: 32'h0, adr1: 32'h0, dat1: 32'h0,
                    tgt0: 2'b00, tgt1: 2'b00};
        vecs[4] = '{bytes: align(160'hA5_01_FC_FF_FF_FF_01_00_01_02_03_04_05_06_07_03, 16), n: 16,
                    slave_en: 1'b1, status: 8'h06, nwr: 2, ncyc: 4,
                    adr0: 32'hFFFFFFFC, dat0: 32'h03020100, adr1: 32'h00000000, dat1: 32'h07060504,
                    tgt0: 2'b10, tgt1: 2'b10};
        vecs[5] = '{bytes: align(160'h11_22_A5_00_10_00_00_00_00_EF_BE_AD_DE_32, 14), n: 14,
                    slave_en: 1'b1, status: 8'h06, nwr: 1, ncyc: 2,
                    adr0: 32'h10, dat0: 32'hDEADBEEF, adr1: 32'h0, dat1: 32'h0,
                    tgt0: 2'b01, tgt1: 2'b00};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        wb_err   = 1'b0;
        slave_en = 1'b1;

        // Reset state.
        #3;
        check("rst rx_ready", 32'(rx_ready), 32'd0);
        check("rst outputs", {22'd0, tx_valid, core_hold, busy, wb_cyc, wb_stb, wb_we,
                              wb_sel}, 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rx_ready before edge", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("rx_ready after edge", 32'(rx_ready), 32'd1);

        for (int i = 0; i < 5; i++) run_frame(i);

        // Asynchronous reset while a write is stuck on the bus.
        slave_en = 1'b0;
        for (int k = 0; k < 11; k++) send_byte(vecs[0].bytes[159 - 8*k -: 8]);
        check("cyc before reset", 32'(wb_cyc), 32'd1);
        check("hold before reset", 32'(core_hold), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-reset bus", {25'd0, wb_cyc, wb_stb, wb_we, wb_sel}, 32'd0);
        check("mid-reset adr_tgt", wb_adr | 32'(wb_tgt), 32'd0);
        check("mid-reset ctrl", {28'd0, core_hold, busy, rx_ready, tx_valid}, 32'd0);
        $display("[TB] mid-frame reset: cyc=%0d hold=%0d busy=%0d", wb_cyc, core_hold, busy);
        @(negedge clk);
        rst_n    = 1'b1;
        slave_en = 1'b1;
        @(negedge clk);
        check("rx_ready after re-reset", 32'(rx_ready), 32'd1);

        run_frame(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
